// File: rtl/ub_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ub_port_arbiter_pkg
// Shared types and constants for the unified-buffer port arbiter.
//   arb_state_t         : FSM state type (IDLE / BURST)
//   REQ_HOST/FETCH/STORE: requester IDs as seen on rdata_id
//   UB_*                : default geometry of the UB port
// ----------------------------------------------------------------------------
package ub_port_arbiter_pkg;

    localparam int UB_N_REQ = 3;
    localparam int UB_AW    = 5;
    localparam int UB_DW    = 8;
    localparam int UB_LW    = 4;
    localparam int UB_IDW   = 2;    // requester ID width (up to 4 requesters)

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_BURST = 1'b1;

    localparam logic [UB_IDW-1:0] REQ_HOST  = 2'd0;
    localparam logic [UB_IDW-1:0] REQ_FETCH = 2'd1;
    localparam logic [UB_IDW-1:0] REQ_STORE = 2'd2;

endpackage

// File: rtl/ub_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// ub_port_arbiter_if
// Bundles the requester side and the UB macro side of the arbiter.
//   slave  : arbiter view (takes requests + mem_rdata, drives grants and UB)
//   master : requesters / UB macro view (the opposite directions)
// Requester fields are packed, requester i at [i*W +: W].
// ----------------------------------------------------------------------------
interface ub_port_arbiter_if #(
    parameter int N_REQ = ub_port_arbiter_pkg::UB_N_REQ,
    parameter int AW    = ub_port_arbiter_pkg::UB_AW,
    parameter int DW    = ub_port_arbiter_pkg::UB_DW,
    parameter int LW    = ub_port_arbiter_pkg::UB_LW
) ();
    // requester side
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    req_we;
    logic [N_REQ*AW-1:0] req_base;
    logic [N_REQ*LW-1:0] req_len;
    logic [N_REQ*DW-1:0] req_wdata;
    logic [N_REQ-1:0]    gnt;
    logic                beat;
    logic [LW-1:0]       beat_idx;
    logic [N_REQ-1:0]    done;
    logic [DW-1:0]       rdata;
    logic                rdata_valid;
    logic [ub_port_arbiter_pkg::UB_IDW-1:0] rdata_id;
    logic                busy;
    // UB macro side
    logic                mem_en;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;

    modport slave (
        input  req, req_we, req_base, req_len, req_wdata, mem_rdata,
        output gnt, beat, beat_idx, done, rdata, rdata_valid, rdata_id, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, req_we, req_base, req_len, req_wdata, mem_rdata,
        input  gnt, beat, beat_idx, done, rdata, rdata_valid, rdata_id, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/ub_port_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping modulo N_REQ.
//   i_req [N_REQ] : request vector
//   i_ptr [IDW]   : highest-priority index (must be < N_REQ)
//   o_gnt [N_REQ] : one-hot winner
//   o_idx [IDW]   : winner index
//   o_any         : at least one request set
// ----------------------------------------------------------------------------
module rr_pick
    import ub_port_arbiter_pkg::*;
#(
    parameter int N_REQ = UB_N_REQ
) (
    input  logic [N_REQ-1:0]  i_req,
    input  logic [UB_IDW-1:0] i_ptr,
    output logic [N_REQ-1:0]  o_gnt,
    output logic [UB_IDW-1:0] o_idx,
    output logic              o_any
);

    // Rotating a doubled copy puts requester i_ptr at bit 0, so a plain
    // low-to-high scan gives round-robin order without variable bit selects.
    logic [2*N_REQ-1:0] w_rot;
    logic [UB_IDW:0]    w_sum;

    assign w_rot = {i_req, i_req} >> i_ptr;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_any && w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (UB_IDW+1)'(k);
                if (w_sum >= (UB_IDW+1)'(N_REQ))
                    w_sum = w_sum - (UB_IDW+1)'(N_REQ);
                o_any = 1'b1;
                o_idx = w_sum[UB_IDW-1:0];
                o_gnt = N_REQ'(1) << w_sum;
            end
        end
    end

endmodule

// File: rtl/ub_port_arbiter.sv
// ----------------------------------------------------------------------------
// ub_port_arbiter
// Shares the single-port unified buffer among N_REQ burst requesters
// (host loader, operand fetch, accumulator store). One burst at a time,
// round-robin, with one IDLE cycle between bursts.
//   clk, reset  : clock, asynchronous active-high reset
//   bus (slave) : req/req_we/req_base/req_len/req_wdata in;
//                 gnt/beat/beat_idx/done/busy out;
//                 rdata/rdata_valid/rdata_id read return;
//                 mem_en/mem_we/mem_addr/mem_wdata to UB, mem_rdata from UB
// ----------------------------------------------------------------------------
module ub_port_arbiter
    import ub_port_arbiter_pkg::*;
#(
    parameter int N_REQ = UB_N_REQ,
    parameter int AW    = UB_AW,
    parameter int DW    = UB_DW,
    parameter int LW    = UB_LW
) (
    input  logic                    clk,
    input  logic                    reset,
    ub_port_arbiter_if.slave        bus
);

    arb_state_t        r_state;
    logic [UB_IDW-1:0] r_rr_ptr;
    logic [UB_IDW-1:0] r_owner;
    logic              r_we;
    logic [AW-1:0]     r_base;
    logic [LW-1:0]     r_len;
    logic [LW-1:0]     r_cnt;
    logic              r_rd_vld;
    logic [UB_IDW-1:0] r_rd_id;

    logic [N_REQ-1:0]  w_pick_gnt;
    logic [UB_IDW-1:0] w_pick_idx;
    logic              w_pick_any;
    logic              w_burst;
    logic              w_last;
    logic [UB_IDW-1:0] w_mux_idx;
    logic              w_sel_we;
    logic [AW-1:0]     w_sel_base;
    logic [LW-1:0]     w_sel_len;
    logic [DW-1:0]     w_sel_wdata;
    logic [N_REQ-1:0]  w_gnt;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req (bus.req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_burst = (r_state == ST_BURST);
    assign w_last  = w_burst && (r_cnt == r_len - LW'(1));

    // In IDLE the mux selects the picker's winner (for latching); in BURST it
    // selects the owner so write data can stream each beat.
    assign w_mux_idx = w_burst ? r_owner : w_pick_idx;

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_base  = '0;
        w_sel_len   = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_mux_idx == UB_IDW'(i)) begin
                w_sel_we    = bus.req_we[i];
                w_sel_base  = bus.req_base[i*AW +: AW];
                w_sel_len   = bus.req_len[i*LW +: LW];
                w_sel_wdata = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_we     <= 1'b0;
            r_base   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_rd_vld <= 1'b0;
            r_rd_id  <= '0;
        end else begin
            // UB read data comes back one cycle after the access
            r_rd_vld <= w_burst && !r_we;
            r_rd_id  <= r_owner;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_owner  <= w_pick_idx;
                        r_we     <= w_sel_we;
                        r_base   <= w_sel_base;
                        r_len    <= (w_sel_len == '0) ? LW'(1) : w_sel_len;
                        r_cnt    <= '0;
                        r_state  <= ST_BURST;
                        r_rr_ptr <= (w_pick_idx == UB_IDW'(N_REQ-1)) ? '0
                                                                     : w_pick_idx + 1'b1;
                    end
                end
                ST_BURST: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_gnt = w_burst ? (N_REQ'(1) << r_owner) : '0;

    assign bus.gnt         = w_gnt;
    assign bus.beat        = w_burst;
    assign bus.beat_idx    = w_burst ? r_cnt : '0;
    assign bus.done        = w_last ? w_gnt : '0;
    assign bus.busy        = w_burst;
    assign bus.mem_en      = w_burst;
    assign bus.mem_we      = w_burst && r_we;
    // address wraps naturally at 2^AW
    assign bus.mem_addr    = w_burst ? (r_base + AW'(r_cnt)) : '0;
    assign bus.mem_wdata   = w_burst ? w_sel_wdata : '0;
    assign bus.rdata_valid = r_rd_vld;
    assign bus.rdata       = r_rd_vld ? bus.mem_rdata : '0;
    assign bus.rdata_id    = r_rd_vld ? r_rd_id : '0;

endmodule
